vga_sync: RTL

VGA_SYNC -- requirements
Module: vga_sync

---
 rtl/vga_pkg.sv | 21 ++
 rtl/vga_sync_pixel_tick_gen.sv | 27 ++
 rtl/vga_sync.sv | 105 ++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants for the sync generator and the pixel generator.
package vga_pkg;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_H_TOTAL   = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_V_TOTAL   = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // True when a counter value lies in [lo, lo+len).
  function automatic logic in_window(input logic [9:0] v, input int lo, input int len);
    return (int'(v) >= lo) && (int'(v) < lo + len);
  endfunction

endpackage

// File: rtl/vga_sync_pixel_tick_gen.sv
// Pixel-enable divider: p_tick is high for one clk out of every CLK_DIV clks.
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q + 1'b1;
    if (div_q == LAST) div_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) div_q <= '0;
    else       div_q <= div_d;
  end

  assign p_tick = (div_q == LAST);

endmodule

// File: rtl/vga_sync.sv
// VGA horizontal/vertical sync generator with pixel counters.
// Optional 16-bit frame counter output enabled by defining VGA_FRAME_CNT_EN.
module vga_sync
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_tick
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  logic [9:0] x_q, x_d, y_q, y_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic       frame_tick_q, frame_tick_d;

  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  // Syncs are computed from the next counter values so they change on the same edge as x/y.
  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    frame_tick_d = 1'b0;
    if (p_tick) begin
      if (x_q == 10'(H_TOTAL - 1)) begin
        x_d = '0;
        if (y_q == 10'(V_TOTAL - 1)) begin
          y_d          = '0;
          frame_tick_d = 1'b1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    hsync_d = ~in_window(x_d, H_DISPLAY + H_FRONT, H_SYNC);
    vsync_d = ~in_window(y_d, V_DISPLAY + V_FRONT, V_SYNC);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q          <= '0;
      y_q          <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_tick_q <= frame_tick_d;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  always_comb begin
    frame_count_d = frame_count_q;
    if (frame_tick_d) frame_count_d = frame_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_count_q <= '0;
    else       frame_count_q <= frame_count_d;
  end

  assign frame_count = frame_count_q;
`endif

  assign x          = x_q;
  assign y          = y_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frame_tick = frame_tick_q;
  assign video_on   = (x_q < 10'(H_DISPLAY)) && (y_q < 10'(V_DISPLAY));

endmodule
